eth_transmitter_dbuf: RTL and testbench

Parametrised next-generation Ethernet transmit front end. The CPU fills a byte buffer through the memory-mapped bus (a/d/n_we/n_oe/n_rdy), programs a frame length and commits. The block streams the frame out of tx_sck/tx_mosi. Two ping-pong banks let the CPU fill frame N+1 while frame N is shifting, and frames shorter than the full buffer are supported.

---
 rtl/eth_transmitter_dbuf.sv | 184 ++++++++++++++++++
 tb/tb_eth_transmitter_dbuf.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/eth_transmitter_dbuf.sv
// Ping-pong buffered serial frame transmitter: the CPU fills one bank over the async bus
// while the other bank is shifted out on tx_sck/tx_mosi framed by tx_ss_n.
module eth_transmitter_dbuf #(
    parameter int          ADDR_BITS   = 10,
    parameter logic [15:0] BUF_BASE    = 16'hF000,
    parameter logic [15:0] CR_ADDR     = 16'hFB00,
    parameter logic [15:0] START_ADDR  = 16'hFB01,
    parameter logic [15:0] LEN_LO_ADDR = 16'hFB02,
    parameter logic [15:0] LEN_HI_ADDR = 16'hFB03,
    parameter int          SCK_DIV     = 2,
    parameter bit          LSB_FIRST   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    inout  wire  [7:0]  d,
    input  logic        n_we,
    input  logic        n_oe,
    output logic        n_rdy,
    output logic        tx_sck,
    output logic        tx_mosi,
    output logic        tx_ss_n
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam int LW    = ADDR_BITS + 1;
    localparam int DW    = $clog2(2 * SCK_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCK_DIV - 1);
    localparam logic [DW-1:0] GAP_LAST = DW'(2 * SCK_DIV - 1);

    typedef enum logic [1:0] {BUS_IDLE, BUS_W1, BUS_W2, BUS_ACK} bus_state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_LOAD, TX_LOW, TX_HIGH, TX_GAP} tx_state_t;

    logic [7:0]           mem [0:2*DEPTH-1];
    bus_state_t           bus_state, bus_state_nxt;
    tx_state_t            tx_state, tx_state_nxt;
    logic                 fill_bank, pending;
    logic [15:0]          len_reg, lat_addr;
    logic                 lat_wr;
    logic [LW-1:0]        frame_len, pend_len, eff_len, byte_idx;
    logic [2:0]           bit_idx;
    logic [DW-1:0]        div_cnt;
    logic [7:0]           byte_data, rd_data, cr_val;
    logic                 strobe, seen, wr_now, commit_now, start, busy;
    logic                 div_done, last_byte, fetch_en, drive_d;
    logic [ADDR_BITS-1:0] fetch_addr;

    function automatic logic is_buf(input logic [15:0] x);
        return ({1'b0, x} >= {1'b0, BUF_BASE}) && ({1'b0, x} < ({1'b0, BUF_BASE} + 17'(DEPTH)));
    endfunction

    function automatic logic is_readable(input logic [15:0] x);
        return is_buf(x) || x == CR_ADDR || x == LEN_LO_ADDR || x == LEN_HI_ADDR;
    endfunction

    assign strobe     = !n_we || !n_oe;
    assign seen       = (bus_state == BUS_IDLE) && strobe;
    assign wr_now     = seen && !n_we;
    assign commit_now = wr_now && (a == START_ADDR);
    assign busy       = (tx_state != TX_IDLE);
    assign start      = (tx_state == TX_IDLE) && (pending || commit_now);
    assign eff_len    = (len_reg == 16'd0 || len_reg > 16'(DEPTH)) ? LW'(DEPTH) : len_reg[LW-1:0];
    assign cr_val     = {5'b00000, pending, !pending, busy};
    assign div_done   = (div_cnt == DIV_LAST);
    assign last_byte  = (byte_idx == frame_len - LW'(1));
    assign fetch_en   = (tx_state == TX_LOAD) || (tx_state == TX_HIGH && div_done && bit_idx == 3'd7);
    assign fetch_addr = (tx_state == TX_LOAD) ? '0 : byte_idx[ADDR_BITS-1:0] + 1'b1;

    assign n_rdy   = (bus_state != BUS_ACK);
    assign drive_d = (bus_state == BUS_ACK) && !lat_wr && !n_oe && is_readable(lat_addr);
    assign d       = drive_d ? rd_data : 8'bz;

    assign tx_sck  = (tx_state == TX_HIGH);
    assign tx_ss_n = !(tx_state == TX_LOAD || tx_state == TX_LOW || tx_state == TX_HIGH);
    assign tx_mosi = (tx_state == TX_LOW || tx_state == TX_HIGH) &&
                     (LSB_FIRST ? byte_data[bit_idx] : byte_data[3'd7 - bit_idx]);

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_state <= BUS_IDLE;
            lat_wr    <= 1'b0;
            lat_addr  <= '0;
        end else begin
            bus_state <= bus_state_nxt;
            if (seen) begin
                lat_wr   <= !n_we;
                lat_addr <= a;
            end
        end
    end

    // Acknowledge two clocks after the strobe is first seen; hold until that strobe releases.
    always_comb begin
        bus_state_nxt = bus_state;
        case (bus_state)
            BUS_IDLE: if (strobe) bus_state_nxt = BUS_W1;
            BUS_W1:   bus_state_nxt = BUS_W2;
            BUS_W2:   bus_state_nxt = BUS_ACK;
            BUS_ACK:  if (lat_wr ? n_we : n_oe) bus_state_nxt = BUS_IDLE;
            default:  bus_state_nxt = BUS_IDLE;
        endcase
    end

    // The tx bank is always the complement of the fill bank, so a swap is a single toggle.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_bank <= 1'b0;
            pending   <= 1'b0;
            len_reg   <= '0;
            frame_len <= '0;
            pend_len  <= '0;
        end else begin
            if (wr_now && a == LEN_LO_ADDR) len_reg[7:0]  <= d;
            if (wr_now && a == LEN_HI_ADDR) len_reg[15:8] <= d;
            if (start) begin
                fill_bank <= ~fill_bank;
                frame_len <= pending ? pend_len : eff_len;
                pending   <= 1'b0;
            end else if (commit_now && !pending) begin
                pending  <= 1'b1;
                pend_len <= eff_len;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_now && is_buf(a) && !pending)
            mem[{fill_bank, a[ADDR_BITS-1:0]}] <= d;
        if (bus_state == BUS_W2) begin
            if (is_buf(lat_addr))              rd_data <= mem[{fill_bank, lat_addr[ADDR_BITS-1:0]}];
            else if (lat_addr == CR_ADDR)      rd_data <= cr_val;
            else if (lat_addr == LEN_LO_ADDR)  rd_data <= len_reg[7:0];
            else if (lat_addr == LEN_HI_ADDR)  rd_data <= len_reg[15:8];
            else                               rd_data <= 8'h00;
        end
        if (fetch_en)
            byte_data <= mem[{~fill_bank, fetch_addr}];
    end

    always_ff @(posedge clk) begin
        if (rst) tx_state <= TX_IDLE;
        else     tx_state <= tx_state_nxt;
    end

    always_comb begin
        tx_state_nxt = tx_state;
        case (tx_state)
            TX_IDLE: if (start) tx_state_nxt = TX_LOAD;
            TX_LOAD: tx_state_nxt = TX_LOW;
            TX_LOW:  if (div_done) tx_state_nxt = TX_HIGH;
            TX_HIGH: if (div_done) tx_state_nxt = (bit_idx == 3'd7 && last_byte) ? TX_GAP : TX_LOW;
            TX_GAP:  if (div_cnt == GAP_LAST) tx_state_nxt = TX_IDLE;
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx <= '0;
            bit_idx  <= '0;
            div_cnt  <= '0;
        end else begin
            case (tx_state)
                TX_LOW:  div_cnt <= div_done ? '0 : div_cnt + 1'b1;
                TX_HIGH: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) byte_idx <= byte_idx + 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                TX_GAP:  div_cnt <= div_cnt + 1'b1;
                default: begin
                    byte_idx <= '0;
                    bit_idx  <= '0;
                    div_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_transmitter_dbuf.sv
// Directed bench: two transmitter instances on one CPU bus at disjoint address windows.
module tb_eth_transmitter_dbuf;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a;
    wire  [7:0]  d;
    logic        n_we, n_oe;
    logic        n_rdy1, tx_sck1, tx_mosi1, tx_ss_n1;
    logic        n_rdy2, tx_sck2, tx_mosi2, tx_ss_n2;
    logic        tb_drive;
    logic [7:0]  tb_d;

    int num_checks = 0;
    int num_fails  = 0;

    assign d = tb_drive ? tb_d : 8'bz;

    always #5 clk = ~clk;

    eth_transmitter_dbuf dut1 (
        .clk(clk), .rst(rst), .a(a), .d(d), .n_we(n_we), .n_oe(n_oe), .n_rdy(n_rdy1),
        .tx_sck(tx_sck1), .tx_mosi(tx_mosi1), .tx_ss_n(tx_ss_n1)
    );

    eth_transmitter_dbuf #(
        .BUF_BASE(16'hE000), .CR_ADDR(16'hEB00), .START_ADDR(16'hEB01),
        .LEN_LO_ADDR(16'hEB02), .LEN_HI_ADDR(16'hEB03), .SCK_DIV(3), .LSB_FIRST(1'b0)
    ) dut2 (
        .clk(clk), .rst(rst), .a(a), .d(d), .n_we(n_we), .n_oe(n_oe), .n_rdy(n_rdy2),
        .tx_sck(tx_sck2), .tx_mosi(tx_mosi2), .tx_ss_n(tx_ss_n2)
    );

    // Receivers: capture mosi at each sck rise (stable across the high phase).
    logic q1[$];
    logic q2[$];
    logic prev1 = 1'b0, prev2 = 1'b0;
    int   ss_bad1 = 0, run2 = 0, hi_min2 = 1000, hi_max2 = 0;

    always @(negedge clk) begin
        if (!prev1 && tx_sck1) begin
            q1.push_back(tx_mosi1);
            if (tx_ss_n1) ss_bad1++;
        end
        prev1 = tx_sck1;
    end

    always @(negedge clk) begin
        if (tx_sck2) begin
            if (!prev2) begin
                q2.push_back(tx_mosi2);
                run2 = 1;
            end else begin
                run2++;
            end
        end else if (prev2) begin
            if (run2 < hi_min2) hi_min2 = run2;
            if (run2 > hi_max2) hi_max2 = run2;
        end
        prev2 = tx_sck2;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [7:0] pat(input int p, input int i);
        case (p)
            0:       return 8'(((i + 1) * 239 + (i >> 2) * 113) & 255);
            1:       return 8'(17 * (i + 1));
            2:       return 8'(i * 7 + 3);
            default: return 8'(i * 13 + 90);
        endcase
    endfunction

    task automatic bus_wait_rdy(input logic level);
        int n = 0;
        while (n_rdy1 !== level && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n_rdy1 !== level) checkOutput("bus_handshake", {31'b0, n_rdy1}, {31'b0, level});
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
        @(negedge clk);
        a = addr; tb_d = data; tb_drive = 1'b1; n_we = 1'b0;
        bus_wait_rdy(1'b0);
        n_we = 1'b1; tb_drive = 1'b0;
        bus_wait_rdy(1'b1);
    endtask

    task automatic bus_read(input logic [15:0] addr, output logic [7:0] data);
        @(negedge clk);
        a = addr; n_oe = 1'b0;
        bus_wait_rdy(1'b0);
        data = d;
        n_oe = 1'b1;
        bus_wait_rdy(1'b1);
    endtask

    task automatic applyStimulus(input logic [15:0] base, input int n, input int p);
        for (int i = 0; i < n; i++) bus_write(base + 16'(i), pat(p, i));
    endtask

    task automatic wait_frame(input int which, input int max_clk);
        int n = 0;
        while ((which == 2 ? tx_ss_n2 : tx_ss_n1) && n < max_clk) begin @(negedge clk); n++; end
        while (!(which == 2 ? tx_ss_n2 : tx_ss_n1) && n < max_clk) begin @(negedge clk); n++; end
        if (n >= max_clk) checkOutput("frame_timeout", n, 0);
    endtask

    task automatic check_frame(input string tag, input int base, input int n, input int p);
        logic [7:0] b;
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 8; j++) b[j] = q1[base + 8 * k + j];
            checkOutput($sformatf("%s_byte%0d", tag, k), {24'b0, b}, {24'b0, pat(p, k)});
        end
    endtask

    logic [7:0] rd;
    int base, snap, gap;

    initial begin
        rst = 1'b1; n_we = 1'b1; n_oe = 1'b1; a = '0; tb_drive = 1'b0; tb_d = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_n_rdy",   {31'b0, n_rdy1},   1);
        checkOutput("rst_sck",     {31'b0, tx_sck1},  0);
        checkOutput("rst_ss_n",    {31'b0, tx_ss_n1}, 1);
        checkOutput("rst_mosi",    {31'b0, tx_mosi1}, 0);
        checkOutput("rst_d_float", {31'b0, (d === 8'bz)}, 1);
        rst = 1'b0;
        bus_read(16'hFB00, rd);  checkOutput("rst_cr", {24'b0, rd}, 32'h02);
        bus_read(16'h1234, rd);  checkOutput("unmapped_read_z", {31'b0, (rd === 8'bz)}, 1);
        bus_write(16'hFB02, 8'h2C);
        bus_read(16'hFB02, rd);  checkOutput("len_lo_rw", {24'b0, rd}, 32'h2C);

        $display("[TB] full-depth frame, LEN=0");
        bus_write(16'hFB02, 8'h00);
        bus_write(16'hFB03, 8'h00);
        applyStimulus(16'hF000, 1024, 0);
        base = q1.size();
        bus_write(16'hFB01, 8'h00);
        wait_frame(1, 40000);
        repeat (10) @(negedge clk);
        checkOutput("full_rises", q1.size() - base, 8192);
        checkOutput("full_ss_low", ss_bad1, 0);
        check_frame("full", base, 1024, 0);
        snap = q1.size();
        repeat (5000) @(negedge clk);
        checkOutput("full_idle_sck", q1.size() - snap, 0);

        $display("[TB] short frame, LEN=5");
        bus_write(16'hFB02, 8'h05);
        applyStimulus(16'hF000, 5, 1);
        base = q1.size();
        bus_write(16'hFB01, 8'h00);
        wait_frame(1, 2000);
        repeat (10) @(negedge clk);
        checkOutput("short_rises", q1.size() - base, 40);
        check_frame("short", base, 5, 1);
        bus_read(16'hFB00, rd);  checkOutput("short_cr_done", {24'b0, rd}, 32'h02);

        $display("[TB] back-to-back frames with pending commit");
        bus_write(16'hFB02, 8'h2C);
        bus_write(16'hFB03, 8'h01);
        applyStimulus(16'hF000, 300, 2);
        base = q1.size();
        bus_write(16'hFB01, 8'h00);
        applyStimulus(16'hF000, 300, 3);
        bus_write(16'hFB01, 8'h00);
        bus_read(16'hFB00, rd);  checkOutput("pend_cr", {24'b0, rd}, 32'h05);
        bus_write(16'hFB01, 8'h00);
        bus_write(16'hF000, 8'hAA);
        bus_read(16'hF000, rd);  checkOutput("pend_write_dropped", {24'b0, rd}, {24'b0, pat(3, 0)});
        bus_read(16'hFB00, rd);  checkOutput("pend_cr_after_3rd", {24'b0, rd}, 32'h05);
        wait_frame(1, 20000);
        gap = 0;
        while (tx_ss_n1 && gap < 50) begin @(negedge clk); gap++; end
        checkOutput("gap_in_range", {31'b0, (gap >= 4 && gap <= 6)}, 1);
        bus_read(16'hFB00, rd);  checkOutput("b_running_cr", {24'b0, rd}, 32'h03);
        wait_frame(1, 20000);
        repeat (10) @(negedge clk);
        bus_read(16'hFB00, rd);  checkOutput("ab_cr_done", {24'b0, rd}, 32'h02);
        checkOutput("ab_rises", q1.size() - base, 4800);
        check_frame("frameA", base, 300, 2);
        check_frame("frameB", base + 2400, 300, 3);

        $display("[TB] MSB-first, SCK_DIV=3 instance");
        bus_write(16'hEB02, 8'h02);
        bus_write(16'hEB03, 8'h00);
        bus_write(16'hE000, 8'h80);
        bus_write(16'hE001, 8'h01);
        bus_write(16'hEB01, 8'h00);
        wait_frame(2, 2000);
        repeat (10) @(negedge clk);
        checkOutput("msb_rises", q2.size(), 16);
        for (int i = 0; i < 16 && i < q2.size(); i++)
            checkOutput($sformatf("msb_bit%0d", i), {31'b0, q2[i]}, {31'b0, (i == 0 || i == 15)});
        checkOutput("msb_hi_min", hi_min2, 3);
        checkOutput("msb_hi_max", hi_max2, 3);

        $display("[TB] reset mid-frame");
        bus_write(16'hFB02, 8'd20);
        bus_write(16'hFB03, 8'h00);
        applyStimulus(16'hF000, 20, 2);
        base = q1.size();
        bus_write(16'hFB01, 8'h00);
        snap = 0;
        while (q1.size() < base + 84 && snap < 2000) begin @(negedge clk); snap++; end
        checkOutput("mid_reached", {31'b0, (q1.size() >= base + 84)}, 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_sck", {31'b0, tx_sck1}, 0);
        checkOutput("abort_ss_n", {31'b0, tx_ss_n1}, 1);
        rst = 1'b0;
        snap = q1.size();
        bus_read(16'hFB00, rd);  checkOutput("abort_cr", {24'b0, rd}, 32'h02);
        bus_read(16'hFB02, rd);  checkOutput("abort_len_lo", {24'b0, rd}, 0);
        bus_read(16'hFB03, rd);  checkOutput("abort_len_hi", {24'b0, rd}, 0);
        repeat (200) @(negedge clk);
        checkOutput("abort_no_sck", q1.size() - snap, 0);
        checkOutput("ss_low_all_rises", ss_bad1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
